// File: rtl/game_selector.sv
// Active-game selector: holds the game index, routes button pulses to that game only,
// and muxes its value onto the display with an ID splash on switch and optional idle blanking.
module game_selector #(
    parameter int N_GAMES        = 4,
    parameter int N_BTN          = 7,
    parameter int ID_SHOW_CYCLES = 1000,
    parameter int IDLE_CYCLES    = 0,
    parameter int WRAP           = 1,
    localparam int SELW          = (N_GAMES > 1) ? $clog2(N_GAMES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_BTN-1:0]         btn_pulse,
    input  logic                     sw_next,
    input  logic                     sw_prev,
    input  logic [4*N_GAMES-1:0]     game_value,
    output logic [N_BTN*N_GAMES-1:0] game_btn,
    output logic [N_GAMES-1:0]       game_sel,
    output logic [SELW-1:0]          game_index,
    output logic [3:0]               display_value,
    output logic                     showing_id
);

    localparam int TW        = $clog2(ID_SHOW_CYCLES + 1);
    localparam int IW        = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int IDLE_LAST = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;

    typedef enum logic [1:0] {S_SHOW_ID, S_PLAY, S_BLANK} state_t;

    state_t          state_reg, state_next;
    logic [SELW-1:0] index_reg, index_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [IW-1:0]   idle_reg, idle_next;
    logic [3:0]      display_reg, display_next;
    logic            sw_req, any_btn, fwd;

    assign sw_req  = sw_next ^ sw_prev;
    assign any_btn = |btn_pulse;
    // A switch pulse in the same cycle swallows the button.
    assign fwd     = (state_reg == S_PLAY) && !sw_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_SHOW_ID;
            index_reg   <= '0;
            timer_reg   <= TW'(ID_SHOW_CYCLES - 1);
            idle_reg    <= '0;
            display_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            timer_reg   <= timer_next;
            idle_reg    <= idle_next;
            display_reg <= display_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        timer_next   = timer_reg;
        idle_next    = idle_reg;
        display_next = display_reg;

        if (sw_req) begin
            if (sw_next) begin
                if (index_reg == SELW'(N_GAMES - 1))
                    index_next = (WRAP != 0) ? '0 : index_reg;
                else
                    index_next = index_reg + 1'b1;
            end else begin
                if (index_reg == '0)
                    index_next = (WRAP != 0) ? SELW'(N_GAMES - 1) : index_reg;
                else
                    index_next = index_reg - 1'b1;
            end
            state_next = S_SHOW_ID;
            timer_next = TW'(ID_SHOW_CYCLES - 1);
            idle_next  = '0;
        end else begin
            case (state_reg)
                S_SHOW_ID: begin
                    idle_next = '0;
                    if (any_btn || timer_reg == '0)
                        state_next = S_PLAY;
                    else
                        timer_next = timer_reg - 1'b1;
                end
                S_PLAY: begin
                    if (any_btn) begin
                        idle_next = '0;
                    end else if (IDLE_CYCLES > 0 && idle_reg == IW'(IDLE_LAST)) begin
                        state_next = S_BLANK;
                        idle_next  = '0;
                    end else if (IDLE_CYCLES > 0) begin
                        idle_next = idle_reg + 1'b1;
                    end
                end
                S_BLANK: begin
                    idle_next = '0;
                    if (any_btn)
                        state_next = S_PLAY;
                end
                default: state_next = S_SHOW_ID;
            endcase
        end

        // Display follows the state being entered so the splash lasts exactly the timer span.
        case (state_next)
            S_SHOW_ID: display_next = 4'(index_next);
            S_PLAY:    display_next = game_value[{index_next, 2'b00} +: 4];
            default:   display_next = 4'd12;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N_GAMES; gi++) begin : g_route
            assign game_sel[gi] = (index_reg == SELW'(gi));
            assign game_btn[N_BTN*gi +: N_BTN] =
                (fwd && index_reg == SELW'(gi)) ? btn_pulse : '0;
        end
    endgenerate

    assign game_index    = index_reg;
    assign display_value = display_reg;
    assign showing_id    = (state_reg == S_SHOW_ID);

endmodule
